// File: rtl/bin_accum_sequencer_if.sv
// FFT-beat / accumulator-write / dump bundle between the bin sequencer (master) and its peers (slave).
// Dump handshake: dump_req is held with dump_bank stable until a cycle with dump_ack=1 and dump_req=1.
// The sequencer drops dump_req the following cycle. dump_ack while dump_req is low has no effect.
interface bin_accum_sequencer_if #(
  parameter int BIN_W = 9
);
  logic             fft_valid;
  logic             fft_sop;
  logic [BIN_W-1:0] bin_num;
  logic             bin_we;
  logic             acc_first;
  logic             dump_req;
  logic             dump_bank;
  logic             dump_ack;

  modport master (
    input  fft_valid, fft_sop, dump_ack,
    output bin_num, bin_we, acc_first, dump_req, dump_bank
  );

  modport slave (
    output fft_valid, fft_sop, dump_ack,
    input  bin_num, bin_we, acc_first, dump_req, dump_bank
  );
endinterface

// File: rtl/bin_accum_sequencer.sv
// Steers the FFT bin stream into ping-pong accumulation banks and hands finished banks to the packetizer.
// Optional idle watchdog (timeout_err port) when BINSEQ_TIMEOUT_EN is defined.
module bin_accum_sequencer #(
  parameter int BINS  = 512,
  parameter int BIN_W = $clog2(BINS)
`ifdef BINSEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 4096
`endif
) (
  input  logic        clk,
  input  logic        areset_n,
  input  logic        enable,
  input  logic [15:0] n_accum,
  bin_accum_sequencer_if.master bus,
  output logic        wr_bank,
  output logic [31:0] acc_count,
  output logic        sync_err,
  output logic        overrun,
`ifdef BINSEQ_TIMEOUT_EN
  output logic        timeout_err,
`endif
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SYNC  = 2'd1,
    S_ACCUM = 2'd2
  } state_t;

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(BINS - 1);

  state_t           state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [15:0]      frame_q, frame_d;
  logic [15:0]      n_lat_q, n_lat_d;
  logic [BIN_W-1:0] bin_num_q, bin_num_d;
  logic             bin_we_q, bin_we_d;
  logic             acc_first_q, acc_first_d;
  logic             wr_bank_q, wr_bank_d;
  logic             dump_req_q, dump_req_d;
  logic             dump_bank_q, dump_bank_d;
  logic [31:0]      acc_count_q, acc_count_d;
  logic             sync_err_q, sync_err_d;
  logic             overrun_q, overrun_d;
  logic [BIN_W-1:0] cur_bin;
  logic [15:0]      cur_frame;
  logic [15:0]      last_frame;

`ifdef BINSEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            timeout_q, timeout_d;
`endif

  // n_accum of 0 behaves as a single-frame accumulation.
  assign last_frame = (n_lat_q == 16'd0) ? 16'd0 : n_lat_q - 16'd1;

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    frame_d     = frame_q;
    n_lat_d     = n_lat_q;
    bin_num_d   = bin_num_q;
    bin_we_d    = 1'b0;
    acc_first_d = 1'b0;
    wr_bank_d   = wr_bank_q;
    dump_bank_d = dump_bank_q;
    acc_count_d = acc_count_q;
    sync_err_d  = sync_err_q;
    overrun_d   = overrun_q;
    dump_req_d  = dump_req_q & ~bus.dump_ack;
    cur_bin     = bin_q;
    cur_frame   = frame_q;
`ifdef BINSEQ_TIMEOUT_EN
    wdog_d      = '0;
    timeout_d   = timeout_q;
`endif

    case (state_q)
      S_IDLE: begin
        bin_d   = '0;
        frame_d = '0;
        if (enable) begin
          state_d = S_SYNC;
          n_lat_d = n_accum;
        end
      end

      S_SYNC: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (bus.fft_valid && bus.fft_sop) begin
          bin_we_d    = 1'b1;
          bin_num_d   = '0;
          acc_first_d = 1'b1;
          bin_d       = BIN_W'(1);
          frame_d     = '0;
          state_d     = S_ACCUM;
        end
      end

      S_ACCUM: begin
        if (bus.fft_valid) begin
          // A mid-frame sop resynchronises: this beat restarts the accumulation at bin 0.
          if (bus.fft_sop && (bin_q != '0)) begin
            sync_err_d = 1'b1;
            cur_bin    = '0;
            cur_frame  = '0;
          end
          bin_we_d    = 1'b1;
          bin_num_d   = cur_bin;
          acc_first_d = (cur_frame == 16'd0);
          bin_d       = cur_bin + BIN_W'(1);
          frame_d     = (cur_bin == LAST_BIN) ? cur_frame + 16'd1 : cur_frame;
          if ((cur_bin == LAST_BIN) && (cur_frame == last_frame)) begin
            frame_d = '0;
            n_lat_d = n_accum;
            if (!dump_req_q || bus.dump_ack) begin
              dump_bank_d = wr_bank_q;
              wr_bank_d   = ~wr_bank_q;
              dump_req_d  = 1'b1;
              acc_count_d = acc_count_q + 32'd1;
            end else begin
              overrun_d = 1'b1;
            end
            if (!enable) state_d = S_IDLE;
          end
        end
`ifdef BINSEQ_TIMEOUT_EN
        else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_SYNC;
          bin_d     = '0;
          frame_d   = '0;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
`endif
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q     <= S_IDLE;
      bin_q       <= '0;
      frame_q     <= '0;
      n_lat_q     <= '0;
      bin_num_q   <= '0;
      bin_we_q    <= 1'b0;
      acc_first_q <= 1'b0;
      wr_bank_q   <= 1'b0;
      dump_req_q  <= 1'b0;
      dump_bank_q <= 1'b0;
      acc_count_q <= '0;
      sync_err_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      frame_q     <= frame_d;
      n_lat_q     <= n_lat_d;
      bin_num_q   <= bin_num_d;
      bin_we_q    <= bin_we_d;
      acc_first_q <= acc_first_d;
      wr_bank_q   <= wr_bank_d;
      dump_req_q  <= dump_req_d;
      dump_bank_q <= dump_bank_d;
      acc_count_q <= acc_count_d;
      sync_err_q  <= sync_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef BINSEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`endif

  assign bus.bin_num   = bin_num_q;
  assign bus.bin_we    = bin_we_q;
  assign bus.acc_first = acc_first_q;
  assign bus.dump_req  = dump_req_q;
  assign bus.dump_bank = dump_bank_q;
  assign wr_bank       = wr_bank_q;
  assign acc_count     = acc_count_q;
  assign sync_err      = sync_err_q;
  assign overrun       = overrun_q;
  assign state_o       = state_q;

endmodule
